// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: shifts a loaded word out MSB-first with optional
// gap-separated repeats, and counts detector hits seen while bits are on the line.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [REP_W-1:0] repeats,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] y_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] aligned_reg, shift_reg, aligned;
  logic [LEN_W-1:0] len_reg, bit_cnt, eff_len;
  logic [REP_W-1:0] rep_cnt;
  logic             accept;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = load_valid && load_ready;

  // Left-justify the valid bits so the first bit to send always sits at the MSB.
  always_comb begin
    eff_len = ((length == '0) || (length > FULL_LEN)) ? FULL_LEN : length;
    aligned = pattern << (FULL_LEN - eff_len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: begin
        if (abort)                state_next = IDLE;
        else if (bit_cnt == '0)   state_next = (rep_cnt != '0) ? GAP : DONE;
      end
      GAP:  state_next = abort ? IDLE : SEND;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aligned_reg <= '0;
      shift_reg   <= '0;
      len_reg     <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      done        <= 1'b0;
      y_count     <= '0;
    end else begin
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      done    <= (state_next == DONE);
      case (state)
        IDLE: if (accept) begin
          aligned_reg <= aligned;
          len_reg     <= eff_len;
          rep_cnt     <= repeats;
          y_count     <= '0;
          shift_reg   <= aligned << 1;
          bit_cnt     <= eff_len - LEN_W'(1);
          x_out       <= aligned[WIDTH-1];
          x_valid     <= 1'b1;
        end
        SEND: begin
          if (y_in && (y_count != CNT_MAX)) y_count <= y_count + CNT_W'(1);
          if (state_next == SEND) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - LEN_W'(1);
            x_out     <= shift_reg[WIDTH-1];
            x_valid   <= 1'b1;
          end
        end
        GAP: if (state_next == SEND) begin
          rep_cnt   <= rep_cnt - REP_W'(1);
          shift_reg <= aligned_reg << 1;
          bit_cnt   <= len_reg - LEN_W'(1);
          x_out     <= aligned_reg[WIDTH-1];
          x_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; a second instance with a 2-bit counter
// shares the stimulus to exercise hit-count saturation.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset, load_valid, abort, y_in;
  logic [7:0] pattern;
  logic [3:0] length, repeats;

  logic       load_ready, x_out, x_valid, busy, done;
  logic [7:0] y_count;
  logic       load_ready2, x_out2, x_valid2, busy2, done2;
  logic [1:0] y_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_pattern_tx dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .length(length), .repeats(repeats), .abort(abort),
    .x_out(x_out), .x_valid(x_valid), .y_in(y_in), .busy(busy), .done(done),
    .y_count(y_count)
  );

  serial_pattern_tx #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready2),
    .pattern(pattern), .length(length), .repeats(repeats), .abort(abort),
    .x_out(x_out2), .x_valid(x_valid2), .y_in(y_in), .busy(busy2), .done(done2),
    .y_count(y_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge of the first SEND cycle.
  task automatic start(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
    check("ready_before_load", load_ready, 1);
    pattern    = pat;
    length     = len;
    repeats    = rep;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    $display("load pattern=%h length=%0d repeat=%0d", pat, len, rep);
  endtask

  // Checks n cycles of x_out/x_valid (MSB of the n-bit fields first), then DONE and IDLE.
  task automatic run_pass(input string tag, input logic [31:0] xs, input logic [31:0] vs,
                          input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      check({tag, "_x"}, x_out, xs[n-1-i]);
      check({tag, "_v"}, x_valid, vs[n-1-i]);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_early"}, done, 0);
      load_valid = (i == poke);
      if (i == poke) pattern = 8'hFF;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_done_xv"}, x_valid, 0);
    check({tag, "_done_ready"}, load_ready, 0);
    check({tag, "_done_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_ready"}, load_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
    $display("pass %s complete y_count=%0d", tag, y_count);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; abort = 1'b0; y_in = 1'b0;
    pattern = '0; length = '0; repeats = '0;
    #3;
    check("rst_x", x_out, 0);
    check("rst_v", x_valid, 0);
    check("rst_done", done, 0);
    check("rst_cnt", y_count, 0);
    check("rst_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    start(8'b0000_1101, 4'd4, 4'd0);
    run_pass("p1101", 32'b1101, 32'b1111, 4, -1);
    check("p1101_cnt", y_count, 0);

    start(8'b10, 4'd2, 4'd2);
    run_pass("rep2", 32'b1001_0010, 32'b1101_1011, 8, 1);

    start(8'hA5, 4'd0, 4'd0);
    run_pass("len0", 32'hA5, 32'hFF, 8, -1);
    start(8'hA5, 4'd12, 4'd0);
    run_pass("len12", 32'hA5, 32'hFF, 8, -1);

    y_in = 1'b1;
    start(8'h0F, 4'd4, 4'd0);
    run_pass("hits4", 32'hF, 32'hF, 4, -1);
    check("hits4_cnt", y_count, 4);
    check("hits4_sat", y_count2, 3);
    start(8'hFF, 4'd8, 4'd0);
    run_pass("hits8", 32'hFF, 32'hFF, 8, -1);
    check("hits8_cnt", y_count, 8);
    check("hits8_sat", y_count2, 3);

    // abort on the third SEND cycle, y_in still high
    start(8'hA5, 4'd8, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_x", x_out, (i == 1) ? 0 : 1);
      check("abort_v", x_valid, 1);
      if (i == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_xv", x_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cnt", y_count, 3);
    @(negedge clk);
    check("abort_nodone", done, 0);
    check("abort_hold", y_count, 3);
    $display("abort transaction complete y_count=%0d", y_count);

    // asynchronous reset mid-SEND
    start(8'hA5, 4'd8, 4'd3);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_v", x_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_x", x_out, 0);
    check("arst_v", x_valid, 0);
    check("arst_done", done, 0);
    check("arst_cnt", y_count, 0);
    check("arst_busy", busy, 0);
    #1 reset = 1'b0;
    y_in = 1'b0;
    @(negedge clk);
    $display("async reset transaction complete");
    start(8'b0000_1101, 4'd4, 4'd0);
    run_pass("post_rst", 32'b1101, 32'b1111, 4, -1);
    check("post_rst_cnt", y_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
